// File: rtl/physical_regfile_mp.sv
// Multi-port physical register file with busy scoreboard and power-on zeroing sweep.
// Optional same-cycle write-to-read bypass is enabled by defining PRF_BYPASS_EN.
module physical_regfile_mp #(
    parameter int REG_SIZE       = 64,
    parameter int REG_SIZE_WIDTH = 6,
    parameter int XLEN           = 64,
    parameter int RD_PORTS       = 4,
    parameter int WR_PORTS       = 4,
    parameter int ALLOC_PORTS    = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [RD_PORTS*REG_SIZE_WIDTH-1:0]  rd_addr_i,
    output logic [RD_PORTS*XLEN-1:0]            rd_data_o,
    output logic [RD_PORTS-1:0]                 rd_ready_o,
    input  logic [WR_PORTS-1:0]                 wr_valid_i,
    input  logic [WR_PORTS*REG_SIZE_WIDTH-1:0]  wr_addr_i,
    input  logic [WR_PORTS*XLEN-1:0]            wr_data_i,
    input  logic [ALLOC_PORTS-1:0]              alloc_valid_i,
    input  logic [ALLOC_PORTS*REG_SIZE_WIDTH-1:0] alloc_addr_i,
    output logic                                init_done_o,
    output logic                                wr_conflict_o
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [REG_SIZE_WIDTH-1:0] LAST_IDX = REG_SIZE_WIDTH'(REG_SIZE - 1);
    localparam logic [REG_SIZE_WIDTH-1:0] ZERO_ADDR = '0;

    state_t                    state;
    logic [REG_SIZE_WIDTH-1:0] idx;
    logic [XLEN-1:0]           regs [REG_SIZE];
    logic [REG_SIZE-1:0]       busy;
    logic                      conflict_c;

    // Two valid writebacks to the same nonzero address in this cycle.
    always_comb begin
        conflict_c = 1'b0;
        for (int i = 0; i < WR_PORTS; i++) begin
            for (int j = i + 1; j < WR_PORTS; j++) begin
                if (wr_valid_i[i] && wr_valid_i[j] &&
                    wr_addr_i[i*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] != ZERO_ADDR &&
                    wr_addr_i[i*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] ==
                    wr_addr_i[j*REG_SIZE_WIDTH +: REG_SIZE_WIDTH])
                    conflict_c = 1'b1;
            end
        end
    end

    // NOTE: the data array has no reset term; the INIT sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= INIT;
            idx           <= '0;
            init_done_o   <= 1'b0;
            wr_conflict_o <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    regs[idx]     <= '0;
                    busy[idx]     <= 1'b0;
                    idx           <= idx + 1'b1;
                    wr_conflict_o <= 1'b0;
                    if (idx == LAST_IDX) begin
                        state       <= RUN;
                        init_done_o <= 1'b1;
                    end
                end
                RUN: begin
                    // Ascending port order: later (higher-index) writes win, and allocations override clears.
                    for (int w = 0; w < WR_PORTS; w++) begin
                        if (wr_valid_i[w] &&
                            wr_addr_i[w*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] != ZERO_ADDR) begin
                            regs[wr_addr_i[w*REG_SIZE_WIDTH +: REG_SIZE_WIDTH]] <= wr_data_i[w*XLEN +: XLEN];
                            busy[wr_addr_i[w*REG_SIZE_WIDTH +: REG_SIZE_WIDTH]] <= 1'b0;
                        end
                    end
                    for (int a = 0; a < ALLOC_PORTS; a++) begin
                        if (alloc_valid_i[a] &&
                            alloc_addr_i[a*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] != ZERO_ADDR)
                            busy[alloc_addr_i[a*REG_SIZE_WIDTH +: REG_SIZE_WIDTH]] <= 1'b1;
                    end
                    wr_conflict_o <= conflict_c;
                end
                default: state <= INIT;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        rd_data_o  = '0;
        rd_ready_o = '0;
        if (state == RUN) begin
            for (int p = 0; p < RD_PORTS; p++) begin
                if (rd_addr_i[p*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] == ZERO_ADDR) begin
                    rd_ready_o[p] = 1'b1;
                end else begin
                    rd_data_o[p*XLEN +: XLEN] = regs[rd_addr_i[p*REG_SIZE_WIDTH +: REG_SIZE_WIDTH]];
                    rd_ready_o[p] = ~busy[rd_addr_i[p*REG_SIZE_WIDTH +: REG_SIZE_WIDTH]];
`ifdef PRF_BYPASS_EN
                    for (int w = 0; w < WR_PORTS; w++) begin
                        if (wr_valid_i[w] &&
                            wr_addr_i[w*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] ==
                            rd_addr_i[p*REG_SIZE_WIDTH +: REG_SIZE_WIDTH]) begin
                            rd_data_o[p*XLEN +: XLEN] = wr_data_i[w*XLEN +: XLEN];
                            rd_ready_o[p] = 1'b1;
                        end
                    end
`else
`endif
                end
            end
        end
    end

endmodule
